// File: rtl/tag_domain_ctrl_pkg.sv
// tag_domain_ctrl_pkg: shared tag encodings, controller states and size defaults.
package tag_domain_ctrl_pkg;
  localparam logic TAG_L = 1'b0;
  localparam logic TAG_H = 1'b1;
  localparam int DEPTH_DEF = 16;
  localparam int IDXW_DEF = 4;
  localparam int DW_DEF = 3;
  typedef enum logic [1:0] {RUN, SCRUB, FLUSH} state_t;
endpackage

// File: rtl/tag_slot_timer.sv
// tag_slot_timer: free-running low/high slot bit, 0 = low slot.
module tag_slot_timer (
  input  logic clk,
  input  logic rst_n,
  output logic slot
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= 1'b0;
    else slot <= ~slot;
endmodule

// File: rtl/tag_domain_ctrl.sv
// tag_domain_ctrl: time-sliced write arbiter and reclassification sequencer for a tagged array.
module tag_domain_ctrl
  import tag_domain_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDXW = IDXW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lo_req_valid,
  input  logic [IDXW-1:0]  lo_req_idx,
  input  logic [DW-1:0]    lo_req_data,
  output logic             lo_req_ready,
  input  logic             hi_req_valid,
  input  logic [IDXW-1:0]  hi_req_idx,
  input  logic [DW-1:0]    hi_req_data,
  output logic             hi_req_ready,
  output logic             hi_req_drop,
  input  logic             reclass_valid,
  input  logic [IDXW-1:0]  reclass_idx,
  input  logic             reclass_to_high,
  output logic             reclass_ready,
  input  logic             flush_start,
  output logic             flush_busy,
  output logic             arr_we,
  output logic [IDXW-1:0]  arr_idx,
  output logic [DW-1:0]    arr_data,
  output logic [DEPTH-1:0] tags_o
);
  logic slot, lo_slot, run_lo, hit, fclr, fclr_n, we_n;
  state_t state, state_n;
  logic [DEPTH-1:0] tags, tags_n;
  logic [IDXW-1:0] sidx, sidx_n, ptr, ptr_n, idx_n;
  logic [DW-1:0] data_n;
  tag_slot_timer u_slot (.clk(clk), .rst_n(rst_n), .slot(slot));
  assign lo_slot = rst_n & ~slot;
  assign run_lo = lo_slot & (state == RUN);
  assign flush_busy = state == FLUSH;
  assign reclass_ready = run_lo & ~flush_start & reclass_valid;
  assign lo_req_ready = run_lo & ~flush_start & ~reclass_valid & lo_req_valid;
  assign hi_req_ready = rst_n & slot & hi_req_valid;
  // the entry mid-declassification must not take fresh H data
  assign hit = (state == SCRUB && hi_req_idx == sidx) || (state == FLUSH && hi_req_idx == ptr);
  assign hi_req_drop = hi_req_ready & (tags[hi_req_idx] == TAG_L | hit);
  assign tags_o = tags;
  always_comb begin
    state_n = state;
    tags_n = tags;
    sidx_n = sidx;
    ptr_n = ptr;
    fclr_n = fclr;
    we_n = 1'b0;
    idx_n = arr_idx;
    data_n = arr_data;
    if (hi_req_ready && !hi_req_drop) begin
      we_n = 1'b1;
      idx_n = hi_req_idx;
      data_n = hi_req_data;
    end
    if (run_lo && flush_start) begin
      state_n = FLUSH;
      ptr_n = '0;
      fclr_n = 1'b0;
    end else if (reclass_ready) begin
      if (reclass_to_high) tags_n[reclass_idx] = TAG_H;
      else if (tags[reclass_idx] == TAG_H) begin
        we_n = 1'b1;
        idx_n = reclass_idx;
        data_n = '0;
        sidx_n = reclass_idx;
        state_n = SCRUB;
      end
    end else if (lo_req_ready) begin
      we_n = 1'b1;
      idx_n = lo_req_idx;
      data_n = lo_req_data;
    end
    if (lo_slot && state == SCRUB) begin
      tags_n[sidx] = TAG_L;
      state_n = RUN;
    end
    // H entries take two low slots (zero data, then relabel); L entries take one
    if (lo_slot && state == FLUSH) begin
      if (!fclr && tags[ptr] == TAG_H) begin
        we_n = 1'b1;
        idx_n = ptr;
        data_n = '0;
        fclr_n = 1'b1;
      end else begin
        if (fclr) tags_n[ptr] = TAG_L;
        fclr_n = 1'b0;
        if (ptr == IDXW'(DEPTH - 1)) state_n = RUN;
        else ptr_n = ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      tags <= '1;
      sidx <= '0;
      ptr <= '0;
      fclr <= 1'b0;
      arr_we <= 1'b0;
      arr_idx <= '0;
      arr_data <= '0;
    end else begin
      state <= state_n;
      tags <= tags_n;
      sidx <= sidx_n;
      ptr <= ptr_n;
      fclr <= fclr_n;
      arr_we <= we_n;
      arr_idx <= idx_n;
      arr_data <= data_n;
    end
endmodule

// File: tb/tb_tag_domain_ctrl.sv
// tb_tag_domain_ctrl: directed and randomized checks against a transaction-level model.
module tb_tag_domain_ctrl;
  localparam int DEPTH = 16, IDXW = 4, DW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic lo_req_valid = 0, hi_req_valid = 0, reclass_valid = 0, reclass_to_high = 0, flush_start = 0;
  logic [IDXW-1:0] lo_req_idx = 0, hi_req_idx = 0, reclass_idx = 0;
  logic [DW-1:0] lo_req_data = 0, hi_req_data = 0;
  logic lo_req_ready, hi_req_ready, hi_req_drop, reclass_ready, flush_busy, arr_we;
  logic [IDXW-1:0] arr_idx;
  logic [DW-1:0] arr_data;
  logic [DEPTH-1:0] tags_o;
  always #5 clk = ~clk;
  tag_domain_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .lo_req_valid(lo_req_valid), .lo_req_idx(lo_req_idx), .lo_req_data(lo_req_data), .lo_req_ready(lo_req_ready),
    .hi_req_valid(hi_req_valid), .hi_req_idx(hi_req_idx), .hi_req_data(hi_req_data),
    .hi_req_ready(hi_req_ready), .hi_req_drop(hi_req_drop),
    .reclass_valid(reclass_valid), .reclass_idx(reclass_idx), .reclass_to_high(reclass_to_high),
    .reclass_ready(reclass_ready), .flush_start(flush_start), .flush_busy(flush_busy),
    .arr_we(arr_we), .arr_idx(arr_idx), .arr_data(arr_data), .tags_o(tags_o)
  );
  int checks = 0, errors = 0;
  // model: tag vector, mode (0 run, 1 scrub, 2 flush), flush as a precomputed step list
  logic [DEPTH-1:0] m_tags;
  int m_mode, m_sidx, m_slot, g_busy;
  int q_idx[$], q_op[$];
  bit g_lo, g_run, e_lr, e_rr, e_hr, e_hd, e_fb, e_we;
  int e_idx, e_data;
  task automatic idle();
    lo_req_valid = 0; hi_req_valid = 0; reclass_valid = 0; flush_start = 0; reclass_to_high = 0;
  endtask
  task automatic model_reset();
    m_tags = '1; m_mode = 0; m_slot = 0; m_sidx = 0;
    q_idx.delete(); q_op.delete();
    e_we = 0; e_idx = 0; e_data = 0;
  endtask
  task automatic rst_release();
    idle();
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
  endtask
  task automatic sample();
    @(negedge clk);
    g_lo = m_slot == 0;
    g_run = g_lo && m_mode == 0;
    e_rr = g_run && !flush_start && reclass_valid;
    e_lr = g_run && !flush_start && !reclass_valid && lo_req_valid;
    e_hr = !g_lo && hi_req_valid;
    g_busy = m_mode == 1 ? m_sidx : (m_mode == 2 ? q_idx[0] : -1);
    e_hd = e_hr && (!m_tags[hi_req_idx] || int'(hi_req_idx) == g_busy);
    e_fb = m_mode == 2;
  endtask
  task automatic advance();
    bit nw;
    int ni, nd, op, oi;
    nw = 0; ni = e_idx; nd = e_data;
    if (e_hr && !e_hd) begin nw = 1; ni = hi_req_idx; nd = hi_req_data; end
    if (g_run && flush_start) begin
      m_mode = 2;
      q_idx.delete(); q_op.delete();
      for (int i = 0; i < DEPTH; i++)
        if (m_tags[i]) begin
          q_idx.push_back(i); q_op.push_back(1); q_idx.push_back(i); q_op.push_back(2);
        end else begin
          q_idx.push_back(i); q_op.push_back(0);
        end
    end else if (e_rr) begin
      if (reclass_to_high) m_tags[reclass_idx] = 1'b1;
      else if (m_tags[reclass_idx]) begin
        nw = 1; ni = reclass_idx; nd = 0; m_mode = 1; m_sidx = reclass_idx;
      end
    end else if (e_lr) begin
      nw = 1; ni = lo_req_idx; nd = lo_req_data;
    end else if (g_lo && m_mode == 1) begin
      m_tags[m_sidx] = 1'b0; m_mode = 0;
    end else if (g_lo && m_mode == 2) begin
      op = q_op.pop_front(); oi = q_idx.pop_front();
      if (op == 1) begin nw = 1; ni = oi; nd = 0; end
      if (op == 2) m_tags[oi] = 1'b0;
      if (q_op.size() == 0) m_mode = 0;
    end
    m_slot ^= 1; e_we = nw; e_idx = ni; e_data = nd;
    @(posedge clk); #1;
  endtask
  task automatic to_lo();
    idle();
    for (int k = 0; k < 2 && m_slot != 0; k++) begin sample(); advance(); end
  endtask
  task automatic run_flush(output int cyc, output logic [DEPTH-1:0] wmask, output int bad);
    cyc = 0; wmask = '0; bad = 0;
    flush_start = 0; lo_req_valid = 1; reclass_valid = 1; reclass_to_high = 1; reclass_idx = 5;
    for (int k = 0; k < 200; k++) begin
      sample();
      if (!flush_busy) begin advance(); break; end
      cyc++;
      if (arr_we) wmask[arr_idx] = 1'b1;
      if (lo_req_ready || reclass_ready) bad++;
      advance();
    end
    idle();
  endtask
  task automatic test_reset();
    lo_req_valid = 1; reclass_valid = 1; hi_req_valid = 1;
    #12;
    checks++;
    if ({lo_req_ready, reclass_ready, hi_req_ready, hi_req_drop} !== 4'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0000", {lo_req_ready, reclass_ready, hi_req_ready, hi_req_drop});
    end
    checks++;
    if ({arr_we, flush_busy, tags_o} !== {2'b00, 16'hFFFF}) begin
      errors++; $display("FAIL reset_state we=%b busy=%b tags=%h exp 0 0 ffff", arr_we, flush_busy, tags_o);
    end
    rst_release();
  endtask
  task automatic test_lo_write();
    lo_req_valid = 1; lo_req_idx = 3; lo_req_data = 5;
    sample();
    checks++;
    if (lo_req_ready !== 1'b1) begin errors++; $display("FAIL lo_first_ready got %b exp 1", lo_req_ready); end
    advance();
    idle();
    sample();
    checks++;
    if ({arr_we, arr_idx, arr_data, tags_o} !== {1'b1, 4'd3, 3'd5, 16'hFFFF}) begin
      errors++; $display("FAIL lo_first_write got we=%b idx=%0d data=%0d tags=%h exp 1 3 5 ffff", arr_we, arr_idx, arr_data, tags_o);
    end
    advance();
  endtask
  task automatic test_reclass_scrub();
    to_lo();
    reclass_valid = 1; reclass_idx = 3; reclass_to_high = 0;
    hi_req_valid = 1; hi_req_idx = 3; hi_req_data = 7;
    sample();
    checks++;
    if (reclass_ready !== 1'b1) begin errors++; $display("FAIL scrub_accept got %b exp 1", reclass_ready); end
    advance();
    reclass_valid = 0;
    sample();
    checks++;
    if ({arr_we, arr_idx, arr_data, hi_req_drop} !== {1'b1, 4'd3, 3'd0, 1'b1}) begin
      errors++; $display("FAIL scrub_write got we=%b idx=%0d data=%0d drop=%b exp 1 3 0 1", arr_we, arr_idx, arr_data, hi_req_drop);
    end
    advance();
    sample();
    checks++;
    if ({arr_we, tags_o[3]} !== 2'b01) begin
      errors++; $display("FAIL scrub_mid got we=%b tag3=%b exp 0 1", arr_we, tags_o[3]);
    end
    advance();
    sample();
    checks++;
    if ({tags_o[3], hi_req_drop} !== 2'b01) begin
      errors++; $display("FAIL scrub_done got tag3=%b drop=%b exp 0 1", tags_o[3], hi_req_drop);
    end
    advance();
    idle();
    sample();
    checks++;
    if (arr_we !== 1'b0) begin errors++; $display("FAIL scrub_no_hi_write got we=%b exp 0", arr_we); end
    advance();
  endtask
  task automatic test_isolation();
    bit lv[40];
    logic [3:0] li[40];
    logic [2:0] ld[40];
    logic [39:0] acc[2], expv;
    expv = '0;
    for (int c = 0; c < 40; c++) begin
      lv[c] = 1'($urandom_range(0, 1)); li[c] = 4'($urandom); ld[c] = 3'($urandom);
      expv[c] = lv[c] && (c % 2 == 0);
    end
    for (int r = 0; r < 2; r++) begin
      to_lo();
      for (int c = 0; c < 40; c++) begin
        lo_req_valid = lv[c]; lo_req_idx = li[c]; lo_req_data = ld[c];
        hi_req_valid = r ? 1'($urandom_range(0, 1)) : 1'b0;
        hi_req_idx = 4'($urandom); hi_req_data = 3'($urandom);
        sample();
        acc[r][c] = lo_req_ready;
        advance();
      end
      idle();
    end
    checks++;
    if (acc[0] !== acc[1]) begin errors++; $display("FAIL iso_timing quiet=%h busy=%h exp equal", acc[0], acc[1]); end
    checks++;
    if (acc[0] !== expv) begin errors++; $display("FAIL iso_accepts got %h exp %h", acc[0], expv); end
  endtask
  task automatic test_flush();
    int cyc, bad, expc;
    logic [DEPTH-1:0] wm;
    to_lo();
    flush_start = 1;
    sample(); advance();
    expc = 2 * (DEPTH + $countones(m_tags));
    run_flush(cyc, wm, bad);
    checks++;
    if (cyc !== expc || tags_o !== 16'h0 || bad !== 0) begin
      errors++; $display("FAIL flush_all got cyc=%0d tags=%h bad=%0d exp %0d 0000 0", cyc, tags_o, bad, expc);
    end
    to_lo();
    reclass_valid = 1; reclass_to_high = 1; reclass_idx = 0;
    sample(); advance();
    idle(); sample(); advance();
    reclass_valid = 1; reclass_to_high = 1; reclass_idx = 2;
    sample(); advance();
    idle(); sample();
    checks++;
    if (tags_o !== 16'h0005) begin errors++; $display("FAIL flush_setup got %h exp 0005", tags_o); end
    advance();
    to_lo();
    flush_start = 1;
    sample(); advance();
    run_flush(cyc, wm, bad);
    checks++;
    if (wm !== 16'h0005 || cyc !== 36 || tags_o !== 16'h0 || bad !== 0) begin
      errors++; $display("FAIL flush_0005 got mask=%h cyc=%0d tags=%h bad=%0d exp 0005 36 0000 0", wm, cyc, tags_o, bad);
    end
  endtask
  task automatic test_priority();
    int cyc, bad;
    logic [DEPTH-1:0] wm;
    to_lo();
    flush_start = 1; reclass_valid = 1; reclass_idx = 7; reclass_to_high = 1;
    lo_req_valid = 1; lo_req_idx = 7; lo_req_data = 2;
    sample();
    checks++;
    if ({reclass_ready, lo_req_ready} !== 2'b00) begin
      errors++; $display("FAIL prio_ready got rr=%b lr=%b exp 0 0", reclass_ready, lo_req_ready);
    end
    advance();
    idle();
    run_flush(cyc, wm, bad);
    checks++;
    if (cyc !== 32 || wm !== 16'h0 || tags_o !== 16'h0) begin
      errors++; $display("FAIL prio_flush got cyc=%0d mask=%h tags=%h exp 32 0000 0000", cyc, wm, tags_o);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      flush_start = ($urandom_range(0, 49) == 0);
      reclass_valid = ($urandom_range(0, 5) == 0);
      reclass_idx = 4'($urandom); reclass_to_high = 1'($urandom_range(0, 1));
      lo_req_valid = 1'($urandom_range(0, 1)); lo_req_idx = 4'($urandom); lo_req_data = 3'($urandom);
      hi_req_valid = 1'($urandom_range(0, 1)); hi_req_idx = 4'($urandom); hi_req_data = 3'($urandom);
      sample();
      checks++;
      if ({lo_req_ready, reclass_ready, hi_req_ready, hi_req_drop, flush_busy} !== {e_lr, e_rr, e_hr, e_hd, e_fb}) begin
        errors++; $display("FAIL rand_ctl cyc %0d got %b exp %b", c,
          {lo_req_ready, reclass_ready, hi_req_ready, hi_req_drop, flush_busy}, {e_lr, e_rr, e_hr, e_hd, e_fb});
      end
      checks++;
      if (arr_we !== e_we || (e_we && (int'(arr_idx) != e_idx || int'(arr_data) != e_data))) begin
        errors++; $display("FAIL rand_wr cyc %0d got we=%b idx=%0d data=%0d exp %b %0d %0d", c, arr_we, arr_idx, arr_data, e_we, e_idx, e_data);
      end
      checks++;
      if (tags_o !== m_tags) begin errors++; $display("FAIL rand_tags cyc %0d got %h exp %h", c, tags_o, m_tags); end
      advance();
    end
    idle();
  endtask
  task automatic test_reset_mid_flush();
    to_lo();
    m_tags = m_tags;
    flush_start = 1;
    sample(); advance();
    idle();
    repeat (7) begin sample(); advance(); end
    checks++;
    if (flush_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", flush_busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({arr_we, flush_busy, tags_o} !== {2'b00, 16'hFFFF}) begin
      errors++; $display("FAIL midrst_state got we=%b busy=%b tags=%h exp 0 0 ffff", arr_we, flush_busy, tags_o);
    end
    rst_release();
    sample();
    checks++;
    if ({arr_we, flush_busy, tags_o} !== {2'b00, 16'hFFFF}) begin
      errors++; $display("FAIL midrst_after got we=%b busy=%b tags=%h exp 0 0 ffff", arr_we, flush_busy, tags_o);
    end
    advance();
  endtask
  initial begin
    model_reset();
    test_reset();
    test_lo_write();
    test_reclass_scrub();
    test_isolation();
    test_flush();
    test_priority();
    test_random();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/tag_domain_ctrl.md
Name: tag_domain_ctrl

Overview:
- Controller and arbiter for a 16-entry security-tagged data array: per-entry 1-bit tag (0 = L, 1 = H); each entry's data takes its label from its tag.
- Owns the tag vector and drives the array's single write port.
- Shares the port between a low-domain writer and a high-domain writer using fixed time-division slots, so low-side timing never depends on high-side activity.
- Sequences reclassification: L->H relabel, H->L scrub-then-relabel, and a whole-array declassify flush.

Parameters:
- DEPTH, 16, number of array entries (power of two).
- IDXW, 4, index width, log2(DEPTH).
- DW, 3, data width.

Ports:
- clk  in  1  clock, label L
- rst_n  in  1  asynchronous active-low reset, label L
- lo_req_valid  in  1  low write request
- lo_req_idx  in  IDXW  low write index
- lo_req_data  in  DW  low write data
- lo_req_ready  out  1  low request accepted this cycle
- hi_req_valid  in  1  high write request, label H
- hi_req_idx  in  IDXW  high write index, label H
- hi_req_data  in  DW  high write data, label H
- hi_req_ready  out  1  high request consumed this cycle, label H
- hi_req_drop  out  1  consumed but discarded (target entry is L), label H
- reclass_valid  in  1  reclassify one entry
- reclass_idx  in  IDXW  entry to reclassify
- reclass_to_high  in  1  1: L->H, 0: H->L
- reclass_ready  out  1  reclass accepted
- flush_start  in  1  declassify all entries
- flush_busy  out  1  flush in progress
- arr_we  out  1  array data write enable
- arr_idx  out  IDXW  array write index
- arr_data  out  DW  array write data, label given by tags_o[arr_idx]
- tags_o  out  DEPTH  current tag vector

Behaviour:
- Reset (asynchronous, rst_n low):
  - tags_o = all 1s (H), so stale array contents are never exposed as L.
  - slot = 0; state = RUN.
  - arr_we = 0; flush_busy = 0; all ready and drop outputs = 0.
- Slot bit:
  - Toggles every cycle after reset, unconditionally.
  - slot = 0 is the low slot; slot = 1 is the high slot.
  - Only control-path (L) state may affect the slot sequence or any low-slot decision.
- Write outputs (arr_we, arr_idx, arr_data) and tag updates are registered: they take effect one cycle after acceptance.
- Low slot, state RUN, priority flush_start > reclass_valid > lo_req_valid:
  - flush_start:
    - Enter FLUSH with ptr = 0 and flush_busy = 1.
    - A simultaneous reclass or lo request is not accepted and must be held.
  - Reclass L->H, or reclass to the class the entry already holds:
    - reclass_ready = 1; tag updated next cycle (no-op if unchanged).
  - Reclass H->L:
    - reclass_ready = 1.
    - Next cycle: arr_we = 1, arr_data = 0 at idx. Enter SCRUB with sidx = idx.
  - Low write:
    - lo_req_ready = 1; write issued next cycle.
    - Permitted to any entry; writing into an H entry is an upgrade.
- High slot:
  - hi_req_ready = 1 if hi_req_valid.
  - Write issued next cycle only if tags_o[idx] = 1 and idx is not the entry being scrubbed (sidx in SCRUB, ptr in FLUSH).
  - Otherwise hi_req_drop = 1 and no write.
  - High requests are consumed in every state.
- SCRUB:
  - At the next low slot, clear tags_o[sidx] and return to RUN.
  - No low requests are accepted during that slot.
- FLUSH, one step per low slot:
  - ptr entry is H: scrub (data write 0), then clear its tag at the following low slot.
  - ptr entry is L: skip.
  - Then ptr++. After ptr = DEPTH-1 completes, return to RUN and clear flush_busy.
  - Flush length depends only on tags (L).
  - lo_req_ready = 0 and reclass_ready = 0 throughout.
- Boundaries:
  - ptr must not wrap during a flush.
  - flush_start during FLUSH or SCRUB is ignored.
  - Reset mid-scrub leaves every tag H; this is safe.

Decomposition:
- Shared package holds:
  - tag encodings TAG_L = 0, TAG_H = 1;
  - state enum RUN/SCRUB/FLUSH;
  - DEPTH, IDXW and DW defaults.
- One sub-module, tag_slot_timer: produces the free-running slot bit.
- Arbitration, FSM and tag register stay in the top level.

Test Plan:
- Reset, then lo write idx 3 data 5 at the first low slot -> lo_req_ready = 1; next cycle arr_we = 1, arr_idx = 3, arr_data = 5; tags_o = 16'hFFFF.
- Reclass idx 3 to L, with continuous high requests to idx 3 -> scrub write of data 0 to idx 3; intervening hi_req_drop = 1; tags_o[3] = 0 two cycles after the scrub write; a later hi write to idx 3 is dropped.
- Toggle hi_req_valid randomly while issuing the same lo sequence -> low-side accept cycles are identical with and without high traffic.
- tags_o = 16'h0005, flush_start -> scrub writes only to idx 0 and 2; flush_busy high until ptr 15 completes; tags_o = 0.
- flush_start, reclass_valid and lo_req_valid all asserted in the same low slot -> only the flush is accepted; reclass_ready = 0 and lo_req_ready = 0.
- rst_n asserted mid-FLUSH -> arr_we = 0 immediately, tags_o = 16'hFFFF, flush_busy = 0.
